out_requant: RTL

Post-processing stage downstream of `macarray`: once the array has written its T×M result into the 16×64 output SRAM, this block reads that SRAM back and converts each signed 16-bit accumulation to signed 8-bit. The conversion is optional ReLU, then rounding arithmetic right shift, then saturation. It packs the results into an 8×64 SRAM in the same row-major layout that `macarray` reads as input. This lets layer outputs feed the next layer directly, with next-layer N equal to this layer's M.

---
 rtl/out_requant_pkg.sv | 40 ++++
 rtl/out_requant_lane.sv | 43 ++++
 rtl/out_requant.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/out_requant_pkg.sv
// Shared types and constants for the output requantizer: FSM encoding,
// MNT field positions, lane widths and the signed 8-bit saturation window.
package out_requant_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR    = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam int M_MSB = 11;
  localparam int M_LSB = 8;
  localparam int T_MSB = 3;
  localparam int T_LSB = 0;

  localparam int ACC_W = 16;
  localparam int Q_W   = 8;

  localparam logic [3:0] DIM_MAX = 4'd8;

  localparam logic signed [ACC_W:0] ROUND_ONE = 17'sd1;
  localparam logic signed [ACC_W:0] SAT_MAX   = 17'sd127;
  localparam logic signed [ACC_W:0] SAT_MIN   = -17'sd128;
  localparam logic [Q_W-1:0]        Q_MAX     = 8'h7F;
  localparam logic [Q_W-1:0]        Q_MIN     = 8'h80;

  // Dimensions above the array size collapse to the array size; zero stays zero.
  function automatic logic [3:0] clamp_dim(input logic [3:0] v);
    logic [3:0] r;
    if (v > DIM_MAX) begin
      r = DIM_MAX;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/out_requant_lane.sv
// One requantization lane: optional ReLU, rounding arithmetic right shift,
// then saturation of a signed 16-bit accumulation to signed 8 bits.
module requant_lane
  import out_requant_pkg::*;
(
  input  logic [ACC_W-1:0] x_i,
  input  logic [3:0]       shift_i,
  input  logic             relu_i,
  output logic [Q_W-1:0]   y_o
);

  // One guard bit keeps x + 2^(shift-1) from wrapping near +32767.
  logic signed [ACC_W:0] x_s;
  logic signed [ACC_W:0] rnd_s;
  logic signed [ACC_W:0] sum_s;
  logic signed [ACC_W:0] y_s;

  always_comb begin
    if (relu_i && x_i[ACC_W-1]) begin
      x_s = '0;
    end else begin
      x_s = $signed({x_i[ACC_W-1], x_i});
    end

    if (shift_i == 4'd0) begin
      rnd_s = '0;
    end else begin
      rnd_s = ROUND_ONE <<< (shift_i - 4'd1);
    end

    sum_s = x_s + rnd_s;
    y_s   = sum_s >>> shift_i;

    if (y_s > SAT_MAX) begin
      y_o = Q_MAX;
    end else if (y_s < SAT_MIN) begin
      y_o = Q_MIN;
    end else begin
      y_o = y_s[Q_W-1:0];
    end
  end

endmodule

// File: rtl/out_requant.sv
// Reads the 16x64 accumulator SRAM row by row (low word, high word), requantizes
// each 16-bit lane to 8 bits and writes one packed 64-bit row per T index.
module out_requant
  import out_requant_pkg::*;
#(
  parameter int LANES_IN  = 4,
  parameter int LANES_OUT = 8,
  parameter int ROWS      = 8
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      START,
  input  logic [11:0]               MNT,
  input  logic [3:0]                SHIFT,
  input  logic                      RELU_EN,
  output logic                      EN_R,
  output logic [3:0]                ADDR_R,
  input  logic [LANES_IN*ACC_W-1:0] RDATA_R,
  output logic                      EN_Q,
  output logic                      RW_Q,
  output logic [2:0]                ADDR_Q,
  output logic [LANES_OUT*Q_W-1:0]  WDATA_Q,
  output logic                      BUSY,
  output logic                      DONE
);

  localparam int         IN_W     = LANES_IN * ACC_W;
  localparam int         HALF_W   = LANES_IN * Q_W;
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  state_e            state_q;
  logic [2:0]        row_q;
  logic [3:0]        m_q;
  logic [3:0]        t_q;
  logic [3:0]        shift_q;
  logic              relu_q;
  logic              start_prev_q;
  logic              row_valid_q;
  logic [HALF_W-1:0] lo_q;
  logic              en_r_q;
  logic [3:0]        addr_r_q;
  logic              en_q_q;
  logic              rw_q_q;
  logic [2:0]        addr_q_q;
  logic              busy_q;
  logic              done_q;

  logic [Q_W-1:0]    lane_s [LANES_IN];
  logic [HALF_W-1:0] lo_d;
  logic [HALF_W-1:0] hi_s;
  logic              start_edge_s;
  logic              row_lt_t_s;
  logic              next_lt_t_s;
  logic [2:0]        row_inc_s;
  logic [3:0]        m_start_s;
  logic [3:0]        t_start_s;
  logic              mnt_n_unused_s;

  // The same four lanes requantize the low word in RD_HI and the high word in WR.
  for (genvar g = 0; g < LANES_IN; g++) begin : g_lane
    requant_lane u_lane (
      .x_i     (RDATA_R[IN_W-1-g*ACC_W -: ACC_W]),
      .shift_i (shift_q),
      .relu_i  (relu_q),
      .y_o     (lane_s[g])
    );
  end

  assign start_edge_s   = START & ~start_prev_q;
  assign row_inc_s      = row_q + 3'd1;
  assign row_lt_t_s     = ({1'b0, row_q} < t_q);
  assign next_lt_t_s    = (({1'b0, row_q} + 4'd1) < t_q);
  assign m_start_s      = clamp_dim(MNT[M_MSB:M_LSB]);
  assign t_start_s      = clamp_dim(MNT[T_MSB:T_LSB]);
  assign mnt_n_unused_s = ^MNT[7:4];

  // Column masking: low word carries columns 1..4, high word columns 5..8.
  always_comb begin
    lo_d = '0;
    hi_s = '0;
    for (int i = 0; i < LANES_IN; i++) begin
      if (4'(i + 1) <= m_q) begin
        lo_d[HALF_W-1-i*Q_W -: Q_W] = lane_s[i];
      end else begin
        lo_d[HALF_W-1-i*Q_W -: Q_W] = '0;
      end
      if (4'(i + 1 + LANES_IN) <= m_q) begin
        hi_s[HALF_W-1-i*Q_W -: Q_W] = lane_s[i];
      end else begin
        hi_s[HALF_W-1-i*Q_W -: Q_W] = '0;
      end
    end
  end

  // Row sequencer; every SRAM strobe is registered one state ahead of use.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_IDLE;
      row_q        <= 3'd0;
      m_q          <= 4'd0;
      t_q          <= 4'd0;
      shift_q      <= 4'd0;
      relu_q       <= 1'b0;
      start_prev_q <= 1'b0;
      row_valid_q  <= 1'b0;
      lo_q         <= '0;
      en_r_q       <= 1'b0;
      addr_r_q     <= 4'd0;
      en_q_q       <= 1'b0;
      rw_q_q       <= 1'b0;
      addr_q_q     <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_prev_q <= START;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_edge_s) begin
            state_q  <= ST_RD_LO;
            row_q    <= 3'd0;
            m_q      <= m_start_s;
            t_q      <= t_start_s;
            shift_q  <= SHIFT;
            relu_q   <= RELU_EN;
            busy_q   <= 1'b1;
            en_r_q   <= (t_start_s != 4'd0);
            addr_r_q <= 4'd0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD_LO: begin
          state_q <= ST_RD_HI;
          en_r_q  <= row_lt_t_s;
          if (row_lt_t_s) begin
            addr_r_q <= {row_q, 1'b1};
          end else begin
            addr_r_q <= 4'd0;
          end
        end
        ST_RD_HI: begin
          state_q     <= ST_WR;
          en_r_q      <= 1'b0;
          addr_r_q    <= 4'd0;
          row_valid_q <= row_lt_t_s;
          if (row_lt_t_s) begin
            lo_q <= lo_d;
          end else begin
            lo_q <= '0;
          end
          en_q_q   <= 1'b1;
          rw_q_q   <= 1'b1;
          addr_q_q <= row_q;
        end
        ST_WR: begin
          en_q_q      <= 1'b0;
          rw_q_q      <= 1'b0;
          addr_q_q    <= 3'd0;
          row_valid_q <= 1'b0;
          if (row_q == LAST_ROW) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RD_LO;
            row_q   <= row_inc_s;
            en_r_q  <= next_lt_t_s;
            if (next_lt_t_s) begin
              addr_r_q <= {row_inc_s, 1'b0};
            end else begin
              addr_r_q <= 4'd0;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          en_r_q  <= 1'b0;
          en_q_q  <= 1'b0;
          rw_q_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign EN_R    = en_r_q;
  assign ADDR_R  = addr_r_q;
  assign EN_Q    = en_q_q;
  assign RW_Q    = rw_q_q;
  assign ADDR_Q  = addr_q_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign WDATA_Q = ((state_q == ST_WR) && row_valid_q) ? {lo_q, hi_s} : '0;

endmodule
